// File: rtl/multiword_instruction_register_pkg.sv
// Shared types and constants for the SAP multi-word instruction register and
// the controller that reads it.
package sap_ir_pkg;

   typedef enum logic [1:0] {
      IR_EMPTY = 2'd0,
      IR_FETCH = 2'd1,
      IR_VALID = 2'd2
   } ir_state_t;

   // drive_sel encodings; DRV_BAD never selects a field.
   localparam logic [1:0] DRV_LOW = 2'd0;
   localparam logic [1:0] DRV_OP1 = 2'd1;
   localparam logic [1:0] DRV_OP2 = 2'd2;
   localparam logic [1:0] DRV_BAD = 2'd3;

   // Instruction length and word counter width (lengths 1..3).
   localparam int LEN_W = 2;

endpackage

// File: rtl/multiword_instruction_register_if.sv
// Control strobes and decoded status between the SAP controller (master) and
// the instruction register (slave). The shared W bus stays a plain inout port.
interface multiword_instruction_register_if
   import sap_ir_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int OPCODE_W  = 4,
   parameter int MAX_WORDS = 3
);

   logic                             load_n;
   logic                             clear_n;
   logic                             output_n;
   logic [1:0]                       drive_sel;
   logic [OPCODE_W-1:0]              opcode;
   logic [(MAX_WORDS-1)*WIDTH-1:0]   operands;
   logic [WIDTH-1:0]                 word0;
   logic [LEN_W-1:0]                 instr_len;
   logic                             instr_valid;
   logic                             error;

   modport master (
      output load_n, clear_n, output_n, drive_sel,
      input  opcode, operands, word0, instr_len, instr_valid, error
   );

   modport slave (
      input  load_n, clear_n, output_n, drive_sel,
      output opcode, operands, word0, instr_len, instr_valid, error
   );

endinterface

// File: rtl/multiword_instruction_register_ir_len_decode.sv
// Opcode -> instruction length in words. Purely combinational so the
// controller microsequencer can share the same decode.
module ir_len_decode
   import sap_ir_pkg::*;
#(
   parameter int                          OPCODE_W   = 4,
   parameter logic [(2**OPCODE_W)-1:0]    TWO_MASK   = 16'h00F0,
   parameter logic [(2**OPCODE_W)-1:0]    THREE_MASK = 16'h0300
) (
   input  logic [OPCODE_W-1:0] opcode,
   output logic [LEN_W-1:0]    instr_len
);

   // Three-word marking takes priority when an opcode appears in both masks.
   always_comb begin
      instr_len = 2'd1;
      if (THREE_MASK[opcode]) begin
         instr_len = 2'd3;
      end else if (TWO_MASK[opcode]) begin
         instr_len = 2'd2;
      end
   end

endmodule

// File: rtl/multiword_instruction_register.sv
// SAP instruction register: gathers an opcode word plus up to MAX_WORDS-1
// operand words from the W bus and can drive a selected field back onto it.
module multiword_instruction_register
   import sap_ir_pkg::*;
#(
   parameter int                          WIDTH      = 8,
   parameter int                          OPCODE_W   = 4,
   parameter int                          MAX_WORDS  = 3,
   parameter logic [(2**OPCODE_W)-1:0]    TWO_MASK   = 16'h00F0,
   parameter logic [(2**OPCODE_W)-1:0]    THREE_MASK = 16'h0300
) (
   input  logic                              clock,
   input  logic                              reset,
   multiword_instruction_register_if.slave   ctl,
   inout  wire  [WIDTH-1:0]                  w_bus
);

   localparam int OPS = MAX_WORDS - 1;

   logic load_req;
   logic clear_req;
   logic drive_req;
   logic load_eff;
   logic sel_bad;

   ir_state_t state_reg, state_next, base_state;
   logic [WIDTH-1:0] word0_reg, word0_next;
   logic [LEN_W-1:0] len_reg, len_next;
   logic [LEN_W-1:0] cnt_reg, cnt_next, cnt_inc;
   logic [LEN_W-1:0] len_dec, len_cap;
   logic             valid_reg, valid_next;
   logic             error_reg, error_next;

   logic [OPS*WIDTH-1:0] ops_flat;
   logic [OPS-1:0]       op_load;
   logic [WIDTH-1:0]     field;

   assign load_req  = ~ctl.load_n;
   assign clear_req = ~ctl.clear_n;
   assign drive_req = ~ctl.output_n;

   // Loading while driving would just capture our own output, so it is dropped.
   assign load_eff = load_req & ~drive_req;
   assign sel_bad  = drive_req & ((ctl.drive_sel == DRV_BAD) || (int'(ctl.drive_sel) > OPS));

   ir_len_decode #(
      .OPCODE_W   (OPCODE_W),
      .TWO_MASK   (TWO_MASK),
      .THREE_MASK (THREE_MASK)
   ) u_len_decode (
      .opcode    (w_bus[WIDTH-1 -: OPCODE_W]),
      .instr_len (len_dec)
   );

   assign len_cap = (int'(len_dec) > MAX_WORDS) ? LEN_W'(MAX_WORDS) : len_dec;
   assign cnt_inc = cnt_reg + 2'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IR_EMPTY;
         word0_reg <= '0;
         len_reg   <= '0;
         cnt_reg   <= '0;
         valid_reg <= 1'b0;
         error_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         word0_reg <= word0_next;
         len_reg   <= len_next;
         cnt_reg   <= cnt_next;
         valid_reg <= valid_next;
         error_reg <= error_next;
      end
   end

   // A clear in the same cycle as a load behaves as if the load hit EMPTY.
   always_comb begin
      state_next = state_reg;
      word0_next = word0_reg;
      len_next   = len_reg;
      cnt_next   = cnt_reg;
      valid_next = valid_reg;
      base_state = state_reg;
      error_next = error_reg | (load_req & drive_req) | sel_bad;

      if (clear_req) begin
         state_next = IR_EMPTY;
         len_next   = '0;
         cnt_next   = '0;
         valid_next = 1'b0;
         base_state = IR_EMPTY;
      end

      if (load_eff) begin
         case (base_state)
            IR_EMPTY: begin
               word0_next = w_bus;
               len_next   = len_cap;
               cnt_next   = 2'd1;
               if (len_cap == 2'd1) begin
                  state_next = IR_VALID;
                  valid_next = 1'b1;
               end else begin
                  state_next = IR_FETCH;
               end
            end
            IR_FETCH: begin
               cnt_next = cnt_inc;
               if (cnt_inc == len_reg) begin
                  state_next = IR_VALID;
                  valid_next = 1'b1;
               end
            end
            IR_VALID: begin
               error_next = 1'b1;
            end
            default: begin
               state_next = IR_EMPTY;
            end
         endcase
      end
   end

   // Operand word gi is written by the load that follows gi+1 captured words.
   for (genvar gi = 0; gi < OPS; gi++) begin : g_op
      logic [WIDTH-1:0] op_reg;

      assign op_load[gi] = load_eff && (base_state == IR_FETCH) && (cnt_reg == LEN_W'(gi + 1));

      always_ff @(posedge clock) begin
         if (reset || clear_req) begin
            op_reg <= '0;
         end else if (op_load[gi]) begin
            op_reg <= w_bus;
         end
      end

      assign ops_flat[gi*WIDTH +: WIDTH] = op_reg;
   end

   always_comb begin
      field = '0;
      if (ctl.drive_sel == DRV_LOW) begin
         field = {{OPCODE_W{1'b0}}, word0_reg[WIDTH-OPCODE_W-1:0]};
      end else begin
         for (int i = 0; i < OPS; i++) begin
            if ((ctl.drive_sel != DRV_BAD) && (int'(ctl.drive_sel) == i + 1)) begin
               field = ops_flat[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   assign w_bus = drive_req ? field : {WIDTH{1'bz}};

   assign ctl.opcode      = word0_reg[WIDTH-1 -: OPCODE_W];
   assign ctl.word0       = word0_reg;
   assign ctl.operands    = ops_flat;
   assign ctl.instr_len   = len_reg;
   assign ctl.instr_valid = valid_reg;
   assign ctl.error       = error_reg;

endmodule
